pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and redirect controller for the 5-stage CPU. Generates the `stall` input of `STAGE_IF` and the IF/ID, ID/EX and EX/MEM flush/bubble controls. It tracks the extra wrong-path fetch that the registered IF output introduces after a MEM-stage redirect, using a small state machine and squash counter. It also implements a debug halt/resume sequence.

---
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and redirect controller for the 5-stage pipeline.
// Drives the IF stall, the ID/EX bubble and the IF/ID, ID/EX and EX/MEM flushes.
// A short squash window covers the extra wrong-path fetch that the registered IF
// output leaves behind after a MEM-stage redirect. A debug halt/resume sequence is
// also handled here.
// Optional feature: define HAZARD_PERF_EN to add the Stall_cnt/Flush_cnt counters.
module pipe_hazard_ctrl #(
    parameter int unsigned SQUASH_EXTRA = 1
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        MEM_PCSrc,
    input  logic        Halt_req,
    input  logic        Resume,
    output logic        stall,
    output logic        IDEX_Bubble,
    output logic        Flush_IFID,
    output logic        Flush_IDEX,
    output logic        Flush_EXMEM,
    output logic [1:0]  State
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] Stall_cnt,
    output logic [31:0] Flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALT   = 2'd2
    } state_t;

    // With zero extra slots the redirect cycle alone is enough and SQUASH is never entered.
    localparam bit         SQ_EN     = (SQUASH_EXTRA != 0);
    localparam logic [2:0] SQ_RELOAD = SQ_EN ? 3'(SQUASH_EXTRA - 1) : 3'd0;

    state_t     state;
    state_t     state_next;
    logic [2:0] sq_cnt;
    logic [2:0] sq_cnt_next;
    logic       pend;
    logic       pend_next;
    logic       lu;
    logic       rs_hit;
    logic       rt_hit;

    // Load-use detection: a load in EX feeding a register the ID instruction reads.
    always_comb begin
        rs_hit = ID_UseRs && (ID_Rs == EX_Rt);
        rt_hit = ID_UseRt && (ID_Rt == EX_Rt);
        lu     = EX_MemRead && (EX_Rt != 5'd0) && (rs_hit || rt_hit);
    end

    // State register with squash counter and pending-redirect flag.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state  <= RUN;
            sq_cnt <= 3'd0;
            pend   <= 1'b0;
        end else begin
            state  <= state_next;
            sq_cnt <= sq_cnt_next;
            pend   <= pend_next;
        end
    end

    // Next-state logic: redirect outranks halt entry, which outranks everything else.
    always_comb begin
        state_next  = state;
        sq_cnt_next = sq_cnt;
        pend_next   = pend;
        case (state)
            RUN: begin
                if (MEM_PCSrc) begin
                    if (SQ_EN) begin
                        state_next  = SQUASH;
                        sq_cnt_next = SQ_RELOAD;
                    end
                end else if (Halt_req) begin
                    state_next = HALT;
                    pend_next  = 1'b0;
                end
            end
            SQUASH: begin
                if (MEM_PCSrc) begin
                    sq_cnt_next = SQ_RELOAD;
                end else if (sq_cnt == 3'd0) begin
                    if (Halt_req) begin
                        state_next = HALT;
                        pend_next  = 1'b0;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    sq_cnt_next = sq_cnt - 3'd1;
                end
            end
            HALT: begin
                if (MEM_PCSrc) begin
                    pend_next = 1'b1;
                end else if (Resume) begin
                    if (pend && SQ_EN) begin
                        state_next  = SQUASH;
                        sq_cnt_next = SQ_RELOAD;
                    end else begin
                        state_next = RUN;
                    end
                    pend_next = 1'b0;
                end
            end
            default: begin
                state_next  = RUN;
                sq_cnt_next = 3'd0;
                pend_next   = 1'b0;
            end
        endcase
    end

    // Mealy outputs: reset forces a full flush, a redirect flushes everything and lets the PC load.
    always_comb begin
        stall       = 1'b0;
        IDEX_Bubble = 1'b0;
        Flush_IFID  = 1'b0;
        Flush_IDEX  = 1'b0;
        Flush_EXMEM = 1'b0;
        if (Clr || MEM_PCSrc) begin
            Flush_IFID  = 1'b1;
            Flush_IDEX  = 1'b1;
            Flush_EXMEM = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    stall       = lu;
                    IDEX_Bubble = lu;
                end
                SQUASH: begin
                    Flush_IFID = 1'b1;
                end
                HALT: begin
                    stall       = 1'b1;
                    IDEX_Bubble = 1'b1;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign State = state;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating counters of stalled cycles and redirect cycles.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (MEM_PCSrc && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign Stall_cnt = stall_cnt;
    assign Flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl with SQUASH_EXTRA = 1, 2 and 3.
// All three instances share one stimulus stream; expected values are hand-computed.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       mem_pc_src;
    logic       halt_req;
    logic       resume;

    logic       stall1, bub1, fifid1, fidex1, fexmem1;
    logic [1:0] state1;
    logic       stall2, bub2, fifid2, fidex2, fexmem2;
    logic [1:0] state2;
    logic       stall3, bub3, fifid3, fidex3, fexmem3;
    logic [1:0] state3;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt1, flush_cnt1;
    logic [31:0] stall_cnt2, flush_cnt2;
    logic [31:0] stall_cnt3, flush_cnt3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .Clk(clk), .Clr(clr), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UseRs(id_use_rs),
        .ID_UseRt(id_use_rt), .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt),
        .MEM_PCSrc(mem_pc_src), .Halt_req(halt_req), .Resume(resume),
        .stall(stall1), .IDEX_Bubble(bub1), .Flush_IFID(fifid1), .Flush_IDEX(fidex1),
        .Flush_EXMEM(fexmem1), .State(state1)
`ifdef HAZARD_PERF_EN
        , .Stall_cnt(stall_cnt1), .Flush_cnt(flush_cnt1)
`endif
    );

    pipe_hazard_ctrl #(.SQUASH_EXTRA(2)) dut2 (
        .Clk(clk), .Clr(clr), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UseRs(id_use_rs),
        .ID_UseRt(id_use_rt), .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt),
        .MEM_PCSrc(mem_pc_src), .Halt_req(halt_req), .Resume(resume),
        .stall(stall2), .IDEX_Bubble(bub2), .Flush_IFID(fifid2), .Flush_IDEX(fidex2),
        .Flush_EXMEM(fexmem2), .State(state2)
`ifdef HAZARD_PERF_EN
        , .Stall_cnt(stall_cnt2), .Flush_cnt(flush_cnt2)
`endif
    );

    pipe_hazard_ctrl #(.SQUASH_EXTRA(3)) dut3 (
        .Clk(clk), .Clr(clr), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UseRs(id_use_rs),
        .ID_UseRt(id_use_rt), .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt),
        .MEM_PCSrc(mem_pc_src), .Halt_req(halt_req), .Resume(resume),
        .stall(stall3), .IDEX_Bubble(bub3), .Flush_IFID(fifid3), .Flush_IDEX(fidex3),
        .Flush_EXMEM(fexmem3), .State(state3)
`ifdef HAZARD_PERF_EN
        , .Stall_cnt(stall_cnt3), .Flush_cnt(flush_cnt3)
`endif
    );

    // Packed view {stall, bubble, flush_ifid, flush_idex, flush_exmem, state} of the default instance.
    wire [6:0] vec1 = {stall1, bub1, fifid1, fidex1, fexmem1, state1};

    function automatic logic [6:0] ev(input logic s, input logic b, input logic f1,
                                      input logic f2, input logic f3, input logic [1:0] st);
        return {s, b, f1, f2, f3, st};
    endfunction

    // Drive every input, then let the combinational outputs settle.
    task automatic applyStimulus(input logic c, input logic pc, input logic hr, input logic rsm,
                                 input logic mr, input logic [4:0] ert,
                                 input logic [4:0] rs, input logic urs,
                                 input logic [4:0] rt, input logic urt);
        clr         = c;
        mem_pc_src  = pc;
        halt_req    = hr;
        resume      = rsm;
        ex_mem_read = mr;
        ex_rt       = ert;
        id_rs       = rs;
        id_use_rs   = urs;
        id_rt       = rt;
        id_use_rt   = urt;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] starting directed sequence");

        // Reset with a redirect and a load-use hazard both present.
        applyStimulus(1, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        tick();
        checkOutput("rst_c1", 32'(vec1), 32'(ev(0, 0, 1, 1, 1, 2'd0)));
        tick();
        checkOutput("rst_c2", 32'(vec1), 32'(ev(0, 0, 1, 1, 1, 2'd0)));
        idle();
        checkOutput("rst_rel", 32'(vec1), 32'(ev(0, 0, 0, 0, 0, 2'd0)));
        checkOutput("rst_rel_s3", 32'(state3), 32'd0);

        // Load-use via Rs.
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        checkOutput("lu_rs", 32'(vec1), 32'(ev(1, 1, 0, 0, 0, 2'd0)));
        tick();
        idle();
        checkOutput("lu_after", 32'(vec1), 32'(ev(0, 0, 0, 0, 0, 2'd0)));
        // Register 0 never hazards.
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        checkOutput("lu_r0", 32'(stall1), 32'd0);
        // Rs not used.
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 0, 5'd0, 0);
        checkOutput("lu_nouse", 32'(stall1), 32'd0);
        // Load-use via Rt.
        applyStimulus(0, 0, 0, 0, 1, 5'd9, 5'd0, 0, 5'd9, 1);
        checkOutput("lu_rt", 32'(vec1), 32'(ev(1, 1, 0, 0, 0, 2'd0)));
        // Full 5-bit compare: 21 vs 5 differ only in bit 4.
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd21, 1, 5'd0, 0);
        checkOutput("lu_5bit", 32'(stall1), 32'd0);
        // Not a load.
        applyStimulus(0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0);
        checkOutput("lu_noload", 32'(stall1), 32'd0);
        tick();

        // Redirect at t with lu true.
        applyStimulus(0, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        checkOutput("redir_t", 32'(vec1), 32'(ev(0, 0, 1, 1, 1, 2'd0)));
        tick();
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        checkOutput("redir_t1", 32'(vec1), 32'(ev(0, 0, 1, 0, 0, 2'd1)));
        checkOutput("redir_t1_s2", 32'(state2), 32'd1);
        checkOutput("redir_t1_s3", 32'(state3), 32'd1);
        tick();
        idle();
        checkOutput("redir_t2", 32'(vec1), 32'(ev(0, 0, 0, 0, 0, 2'd0)));
        checkOutput("redir_t2_s2", 32'(state2), 32'd1);
        checkOutput("redir_t2_s3", 32'(state3), 32'd1);
        checkOutput("redir_t2_f3", 32'(fifid3), 32'd1);
        tick();
        checkOutput("redir_t3_s2", 32'(state2), 32'd0);
        checkOutput("redir_t3_s3", 32'(state3), 32'd1);
        tick();
        checkOutput("redir_t4_s3", 32'(state3), 32'd0);
        tick();

        // Back-to-back redirects at t and t+1.
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        checkOutput("b2b_t1", 32'(vec1), 32'(ev(0, 0, 1, 1, 1, 2'd1)));
        tick();
        idle();
        checkOutput("b2b_t2_s1", 32'(state1), 32'd1);
        checkOutput("b2b_t2_s2", 32'(state2), 32'd1);
        tick();
        checkOutput("b2b_t3_s1", 32'(state1), 32'd0);
        checkOutput("b2b_t3_s2", 32'(state2), 32'd1);
        tick();
        checkOutput("b2b_t4_s2", 32'(state2), 32'd0);
        tick();
        tick();

        // Halt request together with lu: lu acts this cycle, HALT follows.
        applyStimulus(0, 0, 1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        checkOutput("halt_t", 32'(vec1), 32'(ev(1, 1, 0, 0, 0, 2'd0)));
        tick();
        idle();
        checkOutput("halt_t1", 32'(vec1), 32'(ev(1, 1, 0, 0, 0, 2'd2)));
        tick();
        checkOutput("halt_t2", 32'(vec1), 32'(ev(1, 1, 0, 0, 0, 2'd2)));
        tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        checkOutput("halt_redir", 32'(vec1), 32'(ev(0, 0, 1, 1, 1, 2'd2)));
        tick();
        idle();
        checkOutput("halt_t4", 32'(vec1), 32'(ev(1, 1, 0, 0, 0, 2'd2)));
        tick();
        tick();
        applyStimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        checkOutput("halt_t6", 32'(vec1), 32'(ev(1, 1, 0, 0, 0, 2'd2)));
        tick();
        idle();
        checkOutput("resume_t7", 32'(vec1), 32'(ev(0, 0, 1, 0, 0, 2'd1)));
        checkOutput("resume_t7_s3", 32'(state3), 32'd1);
        tick();
        checkOutput("resume_t8", 32'(state1), 32'd0);
        checkOutput("resume_t8_s2", 32'(state2), 32'd1);
        tick();
        tick();
        tick();

        // Resume outside HALT is ignored.
        applyStimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        idle();
        checkOutput("resume_ign", 32'(vec1), 32'(ev(0, 0, 0, 0, 0, 2'd0)));

        // Halt with no pending redirect resumes straight to RUN.
        applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        idle();
        checkOutput("halt_nopend", 32'(state1), 32'd0);

        // Redirect beats halt entry; halt taken on squash exit.
        applyStimulus(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        checkOutput("sq_halt_t1", 32'(state1), 32'd1);
        tick();
        idle();
        checkOutput("sq_halt_t2", 32'(state1), 32'd2);

        // Reset mid-HALT forces outputs and returns to RUN.
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        checkOutput("rst_mid", 32'(vec1), 32'(ev(0, 0, 1, 1, 1, 2'd2)));
        tick();
        idle();
        checkOutput("rst_mid_after", 32'(vec1), 32'(ev(0, 0, 0, 0, 0, 2'd0)));

`ifdef HAZARD_PERF_EN
        // Four load-use stalls and two redirects after a fresh reset.
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd0, 0);
        repeat (4) tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        idle();
        tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        idle();
        tick();
        checkOutput("perf_stall", stall_cnt1, 32'd4);
        checkOutput("perf_flush", flush_cnt1, 32'd2);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        applyStimulus(0, 0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd0, 0);
        tick();
        idle();
        checkOutput("perf_sat", stall_cnt1, 32'hFFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
